addr_hazard_tracker: RTL and testbench
======================================

# addr_hazard_tracker

Upstream driver of the counting bloom filter: tracks addresses of in-flight memory requests and stalls any new request whose address the filter reports as possibly outstanding (RAW/WAW hazard guard). Accepted requests increment the filter and enter an in-order address FIFO; completed responses pop that FIFO and decrement the filter. A flush sequence drains all traffic and clears the filter.

## Interface
Parameters:
- AddrWidth, 32: request address width; equals the filter's InpWidth.
- MaxOutstanding, 8: address FIFO depth, power of two, ≥2.
- CntWidth, $clog2(MaxOutstanding+1): occupancy width (derived, not overridden).

Ports:
- clk_i  in  1  clock, all logic rising-edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i / req_ready_o  in/out  1  upstream request handshake.
- req_addr_i  in  AddrWidth  request address.
- fwd_valid_o / fwd_ready_i  out/in  1  downstream request handshake.
- fwd_addr_o  out  AddrWidth  forwarded address.
- rsp_valid_i, rsp_ready_i  in  1  passively observed response handshake; completion = both high.
- look_data_o  out  AddrWidth  filter lookup address.
- look_valid_i  in  1  filter hit.
- incr_data_o, decr_data_o  out  AddrWidth  filter incr/decr address.
- incr_valid_o, decr_valid_o  out  1  filter incr/decr strobes.
- filter_clear_o  out  1  filter clear.
- flush_i  in  1  flush request (level, sampled in RUN).
- flush_done_o  out  1  one-cycle flush completion pulse.
- outstanding_o  out  CntWidth  FIFO occupancy.
- error_o  out  1  sticky protocol error.

## Operation
- look_data_o = req_addr_i (combinational); hazard = look_valid_i.
- req_ready_o = (state==RUN) & ~flush_i & ~fifo_full & ~hazard & (~fwd_valid_o | fwd_ready_i).
- Accept (req_valid_i & req_ready_o): incr_valid_o=1, incr_data_o=req_addr_i same cycle; push req_addr_i to FIFO; load output register (fwd_valid_o=1, fwd_addr_o=req_addr_i next cycle).
- Output register holds until fwd_ready_i; clears when fwd_ready_i and no new accept.
- Completion with FIFO non-empty: pop head; decr_valid_o=1, decr_data_o=head same cycle.
- Completion with FIFO empty: no pop, no decr, error_o set (see Configuration).
- Push and pop same cycle: occupancy unchanged; full blocks push even if popping.
- FSM (package enum): RUN -> DRAIN when flush_i high in RUN; DRAIN -> CLEAR when FIFO empty & ~fwd_valid_o; CLEAR -> RUN unconditionally. CLEAR drives filter_clear_o=1 and flush_done_o=1 for exactly one cycle. Completions in DRAIN still pop/decr.
- filter_clear_o also 1 while rst_i high.

## Timing
- Reset values: state RUN, FIFO empty, outstanding_o 0, fwd_valid_o 0, fwd_addr_o 0, error_o 0, flush_done_o 0; req_ready_o follows its equation after reset.
- Accept-to-fwd_valid_o latency: 1 cycle; incr strobe 0 cycles after accept; decr strobe 0 cycles after completion.
- Hazard stall is combinational; no bubble on hazard release.
- Flush with nothing outstanding: flush_i cycle N, DRAIN N+1, CLEAR N+2, back in RUN N+3.
- Reset mid-flush or mid-traffic: all state discarded, filter cleared, in-flight responses after reset count as errors.

## Configuration
- ADDR_HAZARD_TRACKER_ERR_EN defined: error_o set on completion with empty FIFO; cleared only by rst_i or CLEAR state.
- Undefined: error_o tied 0, no error register; empty-FIFO completion still ignored.

## Structure
- Package addr_hazard_tracker_pkg: state enum typedef (RUN, DRAIN, CLEAR).
- Sub-module addr_hazard_fifo: synchronous-reset, fall-through-head FIFO with push/pop/full/empty/usage; top holds FSM, output register, filter strobes.

## Test plan
- Accept 0x100, fwd_ready_i=1 -> incr_valid_o with 0x100 same cycle, fwd_valid_o/fwd_addr_o=0x100 next cycle, outstanding_o=1.
- look_valid_i=1 for req 0x100 -> req_ready_o=0 until completion decrements; then same-cycle accept.
- Push 8 addresses, no responses -> outstanding_o=8, req_ready_o=0; one completion -> decr_data_o=first address, 7.
- Simultaneous accept 0x200 and completion of head 0x100 -> incr and decr both strobed, outstanding_o unchanged.
- flush_i with 2 outstanding -> req_ready_o=0, CLEAR entered one cycle after second completion, filter_clear_o and flush_done_o one-cycle pulse.
- Completion with FIFO empty -> no decr, error_o=1 sticky (macro defined), 0 (undefined).

Source files
------------

// File: rtl/addr_hazard_tracker_pkg.sv
// Shared types for the address hazard tracker.
package addr_hazard_tracker_pkg;

    // Tracker control states: normal traffic, flush drain, filter clear.
    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StClear = 2'd2
    } state_e;

endpackage

// File: rtl/addr_hazard_fifo.sv
// In-order address FIFO with fall-through head, synchronous active-high reset.
// Push is ignored when full and pop is ignored when empty.
module addr_hazard_fifo #(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 8,
    parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] usage_o
);
    import addr_hazard_tracker_pkg::*;

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                push_ok, pop_ok;

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and occupancy next-state; pointers wrap since Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset as occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/addr_hazard_tracker.sv
// Hazard guard in front of a counting bloom filter: stalls requests whose
// address may still be in flight, tracks accepted addresses in order and
// drives the filter incr/decr/clear strobes.
// Optional macro ADDR_HAZARD_TRACKER_ERR_EN enables the sticky error flag for
// completions that arrive with nothing outstanding.
module addr_hazard_tracker
    import addr_hazard_tracker_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 fwd_valid_o,
    input  logic                 fwd_ready_i,
    output logic [AddrWidth-1:0] fwd_addr_o,
    input  logic                 rsp_valid_i,
    input  logic                 rsp_ready_i,
    output logic [AddrWidth-1:0] look_data_o,
    input  logic                 look_valid_i,
    output logic [AddrWidth-1:0] incr_data_o,
    output logic [AddrWidth-1:0] decr_data_o,
    output logic                 incr_valid_o,
    output logic                 decr_valid_o,
    output logic                 filter_clear_o,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 error_o
);

    state_e               state_q, state_d;
    logic                 fwd_valid_q, fwd_valid_d;
    logic [AddrWidth-1:0] fwd_addr_q, fwd_addr_d;
    logic                 fifo_full, fifo_empty;
    logic [AddrWidth-1:0] fifo_head;
    logic                 accept, complete, pop;

    assign look_data_o = req_addr_i;
    assign req_ready_o = (state_q == StRun) & ~flush_i & ~fifo_full & ~look_valid_i &
                         (~fwd_valid_q | fwd_ready_i);
    assign accept      = req_valid_i & req_ready_o;
    assign complete    = rsp_valid_i & rsp_ready_i;
    assign pop         = complete & ~fifo_empty;

    assign incr_valid_o   = accept;
    assign incr_data_o    = req_addr_i;
    assign decr_valid_o   = pop;
    assign decr_data_o    = fifo_head;
    assign fwd_valid_o    = fwd_valid_q;
    assign fwd_addr_o     = fwd_addr_q;
    assign filter_clear_o = (state_q == StClear) | rst_i;
    assign flush_done_o   = (state_q == StClear);

    addr_hazard_fifo #(
        .Width    (AddrWidth),
        .Depth    (MaxOutstanding),
        .CntWidth (CntWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (req_addr_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (outstanding_o)
    );

    // Flush sequencing: stop accepting, wait for all traffic to leave, clear filter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (flush_i) state_d = StDrain;
            StDrain: if (fifo_empty && !fwd_valid_q) state_d = StClear;
            StClear: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Forward register: load on accept, drop once consumed with no new accept.
    always_comb begin
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        if (accept) begin
            fwd_valid_d = 1'b1;
            fwd_addr_d  = req_addr_i;
        end else if (fwd_ready_i) begin
            fwd_valid_d = 1'b0;
        end
    end

    // State and forward register update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
        end
    end

`ifdef ADDR_HAZARD_TRACKER_ERR_EN
    logic err_q, err_d;

    // Sticky error on a completion with nothing outstanding; a clear pass resets it.
    always_comb begin
        err_d = err_q;
        if (state_q == StClear)          err_d = 1'b0;
        else if (complete && fifo_empty) err_d = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_addr_hazard_tracker.sv
// Self-checking bench for addr_hazard_tracker: directed scenarios followed by
// random traffic, checked every cycle against a behavioural model whose
// outstanding-address queue doubles as the decr scoreboard.
module tb_addr_hazard_tracker;

    localparam int AW = 32;
    localparam int MO = 8;
    localparam int CW = $clog2(MO + 1);

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic          fwd_valid_o;
    logic          fwd_ready_i = 1'b0;
    logic [AW-1:0] fwd_addr_o;
    logic          rsp_valid_i = 1'b0;
    logic          rsp_ready_i = 1'b0;
    logic [AW-1:0] look_data_o;
    logic          look_valid_i = 1'b0;
    logic [AW-1:0] incr_data_o, decr_data_o;
    logic          incr_valid_o, decr_valid_o;
    logic          filter_clear_o;
    logic          flush_i = 1'b0;
    logic          flush_done_o;
    logic [CW-1:0] outstanding_o;
    logic          error_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addr_hazard_tracker #(
        .AddrWidth      (AW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .fwd_valid_o    (fwd_valid_o),
        .fwd_ready_i    (fwd_ready_i),
        .fwd_addr_o     (fwd_addr_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_ready_i    (rsp_ready_i),
        .look_data_o    (look_data_o),
        .look_valid_i   (look_valid_i),
        .incr_data_o    (incr_data_o),
        .decr_data_o    (decr_data_o),
        .incr_valid_o   (incr_valid_o),
        .decr_valid_o   (decr_valid_o),
        .filter_clear_o (filter_clear_o),
        .flush_i        (flush_i),
        .flush_done_o   (flush_done_o),
        .outstanding_o  (outstanding_o),
        .error_o        (error_o)
    );

    task automatic check_val(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: 0 = run, 1 = drain, 2 = clear.
    logic [AW-1:0] m_q [$];
    int            m_state = 0;
    logic          m_fwd_v = 1'b0;
    logic [AW-1:0] m_fwd_a = '0;
    logic          m_err = 1'b0;
    logic          m_init = 1'b0;

    // Inputs change at posedge+1, so the negedge sees a stable cycle.
    always @(negedge clk) begin
        logic m_ready, acc, comp, pop;
        if (rst_i) begin
            check_val("clear_in_reset", {31'd0, filter_clear_o}, 1);
            m_q.delete();
            m_state = 0;
            m_fwd_v = 1'b0;
            m_fwd_a = '0;
            m_err   = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            m_ready = (m_state == 0) && !flush_i && (m_q.size() < MO) && !look_valid_i &&
                      (!m_fwd_v || fwd_ready_i);
            acc  = req_valid_i && m_ready;
            comp = rsp_valid_i && rsp_ready_i;
            pop  = comp && (m_q.size() > 0);

            check_val("look_data", look_data_o, req_addr_i);
            check_val("req_ready", {31'd0, req_ready_o}, {31'd0, m_ready});
            check_val("incr_valid", {31'd0, incr_valid_o}, {31'd0, acc});
            if (acc) check_val("incr_data", incr_data_o, req_addr_i);
            check_val("decr_valid", {31'd0, decr_valid_o}, {31'd0, pop});
            if (pop) check_val("decr_data", decr_data_o, m_q[0]);
            check_val("outstanding", {{(AW-CW){1'b0}}, outstanding_o}, m_q.size());
            check_val("fwd_valid", {31'd0, fwd_valid_o}, {31'd0, m_fwd_v});
            if (m_fwd_v) check_val("fwd_addr", fwd_addr_o, m_fwd_a);
            check_val("filter_clear", {31'd0, filter_clear_o}, (m_state == 2) ? 1 : 0);
            check_val("flush_done", {31'd0, flush_done_o}, (m_state == 2) ? 1 : 0);
`ifdef ADDR_HAZARD_TRACKER_ERR_EN
            check_val("error", {31'd0, error_o}, {31'd0, m_err});
`else
            check_val("error", {31'd0, error_o}, 0);
`endif
            // Next-state, using this cycle's values.
            if (m_state == 2)                comp = comp; // clear pass wipes error below
            if (m_state == 2)                m_err = 1'b0;
            else if (comp && m_q.size() == 0) m_err = 1'b1;
            case (m_state)
                0: if (flush_i) m_state = 1;
                1: if (m_q.size() == 0 && !m_fwd_v) m_state = 2;
                default: m_state = 0;
            endcase
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(req_addr_i);
                m_fwd_v = 1'b1;
                m_fwd_a = req_addr_i;
            end else if (fwd_ready_i) begin
                m_fwd_v = 1'b0;
            end
        end
    end

    task automatic cyc(input logic rv, input logic [AW-1:0] a, input logic fr, input logic rsp,
                       input logic fl, input logic lk);
        req_valid_i  = rv;
        req_addr_i   = a;
        fwd_ready_i  = fr;
        rsp_valid_i  = rsp;
        rsp_ready_i  = rsp;
        flush_i      = fl;
        look_valid_i = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) cyc(0, '0, 1, 0, 0, 0);
        rst_i = 1'b0;
    endtask

    initial begin
        #1;
        do_reset(2);
        // Single accept, forwarded next cycle.
        cyc(1, 32'h100, 1, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0, 0);
        // Hazard stall on 0x100 until its completion decrements the filter.
        cyc(1, 32'h100, 1, 0, 0, 1);
        cyc(1, 32'h100, 1, 0, 0, 1);
        cyc(0, 32'h0, 1, 1, 0, 1);
        cyc(1, 32'h100, 1, 0, 0, 0);
        // Fill to capacity; full blocks push even when popping.
        for (int i = 0; i < 7; i++) cyc(1, 32'h300 + i, 1, 0, 0, 0);
        cyc(1, 32'h999, 1, 0, 0, 0);
        cyc(1, 32'h999, 1, 1, 0, 0);
        // Accept and completion together.
        cyc(1, 32'h200, 1, 1, 0, 0);
        // Downstream backpressure holds the output register.
        cyc(1, 32'h400, 0, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0, 0);
        // Drain down to two outstanding, then flush.
        repeat (5) cyc(0, 32'h0, 1, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 1, 0);
        cyc(1, 32'h500, 1, 0, 0, 0);
        cyc(0, 32'h0, 1, 1, 0, 0);
        cyc(0, 32'h0, 1, 1, 0, 0);
        repeat (3) cyc(0, 32'h0, 1, 0, 0, 0);
        // Completion with nothing outstanding.
        cyc(0, 32'h0, 1, 1, 0, 0);
        repeat (2) cyc(0, 32'h0, 1, 0, 0, 0);
        // Idle flush clears the error.
        cyc(0, 32'h0, 1, 0, 1, 0);
        repeat (4) cyc(0, 32'h0, 1, 0, 0, 0);
        // Reset mid-traffic; late response counts as an error.
        cyc(1, 32'h600, 1, 0, 0, 0);
        cyc(1, 32'h604, 0, 0, 0, 0);
        do_reset(1);
        cyc(0, 32'h0, 1, 1, 0, 0);
        repeat (2) cyc(0, 32'h0, 1, 0, 0, 0);
        do_reset(1);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            req_valid_i  = ($urandom_range(0, 3) != 0);
            req_addr_i   = $urandom;
            fwd_ready_i  = ($urandom_range(0, 3) != 0);
            rsp_valid_i  = ($urandom_range(0, 2) == 0);
            rsp_ready_i  = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 40) == 0);
            look_valid_i = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
        end
        cyc(0, 32'h0, 1, 0, 0, 0);
        repeat (2) cyc(0, 32'h0, 1, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
